// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   Asynchronous serial receiver driven by a 16x oversampling tick. It detects
//   the start bit, samples each data bit at its midpoint, shifts bits in LSB
//   first, checks the stop bit and strobes the received word out.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     Defined: adds an even-parity bit after the data bits and a parity_err port.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   s_tick       : one-clk pulse at 16x baud
//   rx           : serial line, asynchronous, idle high
//   dout         : last received word (LSB = first bit on the line)
//   rx_done_tick : one-clk strobe when a frame completes
//   frame_err    : stop bit sampled low on the completed frame
//   parity_err   : parity mismatch on the completed frame (parity builds only)
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [SW-1:0]   stop_q, stop_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_q;
  logic            ferr_q;
  logic            rx_meta, rx_s;
  logic            done;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q;
`endif

  // Two-flop synchronizer; idle level is 1 so reset must not look like a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      stop_q  <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
      if (done) begin
        dout_q <= shreg_q;
        ferr_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        perr_q <= (^shreg_q) ^ par_q;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // Start detection is level based and does not wait for a tick.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;  // line went back high: glitch, not a start
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              stop_d  = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            par_d   = rx_s;
            stop_d  = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (stop_q == SW'(SB_TICK - 1)) begin
            done    = 1'b1;
            stop_d  = '0;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion outputs bypass their holding registers in the strobe cycle so
  // the word and flags are valid together with rx_done_tick.
  assign rx_done_tick = done;
  assign dout         = done ? shreg_q : dout_q;
  assign frame_err    = done ? ~rx_s : ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = done ? ((^shreg_q) ^ par_q) : perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam int LAT = 168;
`else
  localparam int LAT = 152;
`endif

  int checks = 0;
  int errors = 0;

  // strobe monitor state
  int   done_cnt = 0;
  int   tick_acc = 0;
  int   strobe_ticks = -1;
  bit   arm = 1'b0;
  bit   prev_done = 1'b0;
  bit   dbl = 1'b0;
  logic [7:0] hd [0:63];
  logic       hf [0:63];
  logic       hp [0:63];

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // baud generator: one tick every 4 clocks
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (!arm) tick_acc = 0;
    else if (s_tick) tick_acc++;
    if (rx_done_tick === 1'b1) begin
      if (done_cnt < 64) begin
        hd[done_cnt] = dout;
        hf[done_cnt] = frame_err;
`ifdef UART_RX_PARITY_EN
        hp[done_cnt] = parity_err;
`else
        hp[done_cnt] = 1'b0;
`endif
      end
      done_cnt++;
      strobe_ticks = tick_acc;
      if (prev_done) dbl = 1'b1;
    end
    prev_done = (rx_done_tick === 1'b1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(64);
  endtask

  // 64 clk per bit; arm the tick counter 3 clocks after the start edge, the
  // cycle from which the receiver begins counting start-bit ticks.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    rx = 1'b0;
    wait_clks(3);
    arm = 1'b1;
    wait_clks(61);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    if (stop_bit) begin
      send_bit(1'b1);
    end else begin
      // low through the stop midpoint, then idle
      rx = 1'b0;
      wait_clks(40);
      rx = 1'b1;
      wait_clks(24);
    end
    rx = 1'b1;
    arm = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: dout=%h frame_err=%b done=%b, expected 00/0/0", dout, frame_err, rx_done_tick);
    end
`ifdef UART_RX_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity_err: got %b expected 0", parity_err);
    end
`endif
    wait_clks(1);
  endtask

  task automatic test_single_byte;
    int base;
    base = done_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_clks(4);
    checks++;
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL single_strobes: got %0d expected 1", done_cnt - base);
    end else begin
      checks++;
      if (hd[base] !== 8'hA5 || hf[base] !== 1'b0) begin
        errors++;
        $display("FAIL single_data: dout=%h ferr=%b expected a5/0", hd[base], hf[base]);
      end
`ifdef UART_RX_PARITY_EN
      checks++;
      if (hp[base] !== 1'b0) begin
        errors++;
        $display("FAIL single_parity: got %b expected 0", hp[base]);
      end
`endif
    end
    checks++;
    if (strobe_ticks != LAT) begin
      errors++;
      $display("FAIL single_latency: got %0d ticks expected %0d", strobe_ticks, LAT);
    end
  endtask

  task automatic test_glitch;
    int base;
    base = done_cnt;
    rx = 1'b0;
    wait_clks(12);
    rx = 1'b1;
    wait_clks(700);
    checks++;
    if (done_cnt != base) begin
      errors++;
      $display("FAIL glitch_strobe: got %0d strobes expected 0", done_cnt - base);
    end
    checks++;
    if (dout !== 8'hA5 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_hold: dout=%h ferr=%b expected a5/0", dout, frame_err);
    end
  endtask

  task automatic test_framing;
    int base;
    base = done_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_clks(64);
    checks++;
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL ferr_strobes: got %0d expected 1", done_cnt - base);
    end else begin
      checks++;
      if (hd[base] !== 8'h3C || hf[base] !== 1'b1) begin
        errors++;
        $display("FAIL ferr_data: dout=%h ferr=%b expected 3c/1", hd[base], hf[base]);
      end
    end
    checks++;
    if (dout !== 8'h3C || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_hold: dout=%h ferr=%b expected 3c/1", dout, frame_err);
    end
    send_frame(8'h01, 1'b1, ^8'h01);
    wait_clks(4);
    checks++;
    if (done_cnt - base != 2) begin
      errors++;
      $display("FAIL ferr_clear_strobes: got %0d expected 2", done_cnt - base);
    end else begin
      checks++;
      if (hd[base+1] !== 8'h01 || hf[base+1] !== 1'b0) begin
        errors++;
        $display("FAIL ferr_clear: dout=%h ferr=%b expected 01/0", hd[base+1], hf[base+1]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] exp [0:2];
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'h55;
    base = done_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, ^exp[i]);
    wait_clks(4);
    checks++;
    if (done_cnt - base != 3) begin
      errors++;
      $display("FAIL b2b_strobes: got %0d expected 3", done_cnt - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hd[base+i] !== exp[i] || hf[base+i] !== 1'b0 || hp[base+i] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_frame%0d: dout=%h ferr=%b perr=%b expected %h/0/0",
                   i, hd[base+i], hf[base+i], hp[base+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    logic [7:0] d;
    d = 8'h5A;
    base = done_cnt;
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    wait_clks(32);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values: dout=%h ferr=%b done=%b expected 00/0/0", dout, frame_err, rx_done_tick);
    end
    rx = 1'b1;
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(12 * 64);
    checks++;
    if (done_cnt != base || dout !== 8'h00) begin
      errors++;
      $display("FAIL midreset_nostrobe: strobes=%0d dout=%h expected 0/00", done_cnt - base, dout);
    end
    send_frame(8'h81, 1'b1, ^8'h81);
    wait_clks(4);
    checks++;
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL midreset_next_strobes: got %0d expected 1", done_cnt - base);
    end else begin
      checks++;
      if (hd[base] !== 8'h81 || hf[base] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_next: dout=%h ferr=%b expected 81/0", hd[base], hf[base]);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int base;
    base = done_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(4);
    checks++;
    if (done_cnt - base != 2) begin
      errors++;
      $display("FAIL parity_strobes: got %0d expected 2", done_cnt - base);
    end else begin
      checks++;
      if (hd[base] !== 8'h07 || hp[base] !== 1'b0) begin
        errors++;
        $display("FAIL parity_good: dout=%h perr=%b expected 07/0", hd[base], hp[base]);
      end
      checks++;
      if (hd[base+1] !== 8'h07 || hp[base+1] !== 1'b1) begin
        errors++;
        $display("FAIL parity_bad: dout=%h perr=%b expected 07/1", hd[base+1], hp[base+1]);
      end
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    rx = 1'b1;
    wait_clks(3);
    test_reset;
    reset_n = 1'b1;
    wait_clks(5);
    test_single_byte;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    checks++;
    if (dbl) begin
      errors++;
      $display("FAIL strobe_width: rx_done_tick high for more than one cycle, expected single-cycle pulses");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Asynchronous serial receiver for the UART slave datapath. It consumes the 16x-oversampling `tick` from the baud generator, detects a start bit on `rx`, and samples each data bit at its midpoint. It shifts the bits in LSB-first, checks the stop bit, and presents the received byte with a one-cycle completion strobe to the Wishbone-side register and FIFO logic.

## Interface
- `DBIT`, default 8: data bits per frame, legal range 5–9.
- `SB_TICK`, default 16: stop-bit length in ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `s_tick` input, 1 bit: one-`clk` pulse at 16× the baud rate, driven by the baud generator `tick`.
- `rx` input, 1 bit: serial line, asynchronous to `clk`, idle high.
- `dout` output, DBIT bits: last received data word, LSB = first bit on the line.
- `rx_done_tick` output, 1 bit: one-`clk` pulse when a frame completes.
- `frame_err` output, 1 bit: stop bit was sampled low for the frame just completed.
- `parity_err` output, 1 bit: exists only when `UART_RX_PARITY_EN` is defined (see Configuration).

## Operation
- **Input synchronizer.** `rx` passes through two flops, both reset to 1. All decisions use the synchronized value `rx_s`.
- **Counters.**
  - Tick counter `s`: 4 bits, wraps 15→0. It advances only on cycles where `s_tick`=1.
  - Bit counter `n`: sized for DBIT−1.
  - Stop counter: sized for SB_TICK−1.
- **State machine:** IDLE, START, DATA, (PARITY), STOP.
- **IDLE**
  - When `rx_s`=0, go to START and clear `s`.
  - This transition does not wait for `s_tick`.
- **START**
  - On each `s_tick`, increment `s`.
  - At the tick where `s`=7 (the start-bit midpoint):
    - If `rx_s`=0, go to DATA with `s`=0 and `n`=0.
    - If `rx_s`=1, the start was a glitch: return to IDLE with no strobe and no error.
- **DATA**
  - On the tick where `s`=15, clear `s` and shift right: shift register ← {`rx_s`, shreg[DBIT-1:1]}.
  - If `n`=DBIT−1, go to STOP (or PARITY); otherwise increment `n`.
- **STOP**
  - Count SB_TICK ticks.
  - On the last tick:
    - pulse `rx_done_tick`;
    - load `dout` ← shift register;
    - load `frame_err` ← ~`rx_s`;
    - go to IDLE.
- **Holding.** `dout` and `frame_err` hold their values until the next frame completes. A new frame may start in the `clk` cycle after return to IDLE.
- **Reset mid-frame.** The frame is aborted:
  - state = IDLE, all counters = 0, shift register = 0;
  - no `rx_done_tick` is produced.
- **Line held low (break).** The frame completes with `frame_err`=1 and `dout`=0. The block then re-enters START immediately because `rx_s` is still 0; this is the required behaviour.

## Timing
- **Reset values:** `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, state = IDLE.
- **Synchronizer latency:** 2 `clk` cycles from a pad edge to `rx_s`.
- **Sample points:** data bit k is sampled at tick 8+16·(k+1) after start detection. That is 16 ticks per bit, centred on the bit midpoint.
- **Frame latency:** from start detection to `rx_done_tick`, 8 + 16·DBIT + SB_TICK ticks, plus 16 more with parity enabled. For DBIT=8 and SB_TICK=16 this is 152 ticks.
- **Strobe and outputs:** `rx_done_tick` is high for exactly one `clk` cycle, coincident with the `s_tick` cycle that ends STOP. `dout`, `frame_err` and `parity_err` are valid in that same cycle.
- **`s_tick` stuck high:** ticks are counted every `clk`; the logic must not break in this case.

## Configuration
- **Macro `UART_RX_PARITY_EN`.**
- **Defined:**
  - Adds the `parity_err` output port and a PARITY state between DATA and STOP.
  - In PARITY, one bit is sampled at `s`=15.
  - `parity_err` ← (XOR of the data bits XOR the sampled parity bit) ≠ 0, i.e. even parity. It is loaded with `dout`.
- **Undefined:**
  - No `parity_err` port and no PARITY state.
  - DATA goes directly to STOP.

## Test plan
- **Single byte.** Baud generator with BAUD_COUNTER=4. Drive a frame carrying 0xA5 with 1 stop bit -> exactly one `rx_done_tick`, `dout`=0xA5, `frame_err`=0, 152 ticks after the start edge is synchronized.
- **Glitch rejection.** Pulse `rx` low for 3 ticks and return high -> state goes back to IDLE, no `rx_done_tick`, `dout` unchanged.
- **Framing error.** Send 0x3C with the stop bit driven low -> `rx_done_tick` pulses, `dout`=0x3C, `frame_err`=1. The next clean frame with 0x01 -> `frame_err`=0.
- **Back-to-back frames.** Send 0x00, 0xFF, 0x55 with no idle gap -> three strobes, `dout` values in that order, no errors.
- **Reset mid-frame.** Assert `reset_n`=0 during data bit 4 of a frame -> outputs return to reset values, no strobe. A following frame with 0x81 is received correctly.
- **Parity (`UART_RX_PARITY_EN` defined).**
  - 0x07 with parity bit 1 -> `parity_err`=0.
  - 0x07 with parity bit 0 -> `parity_err`=1.
